// File: rtl/dtw_pkg.sv
// dtw_pkg: definitions shared by the DTW run scheduler and its watchdog.
// Holds the scheduler state encoding, which is also the value on state_o
// for the status register. It also holds the err_code values and the core
// operating-mode values.
package dtw_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSTC    = 3'd1,
    ARM     = 3'd2,
    RUN_REF = 3'd3,
    RUN_Q   = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  localparam logic MODE_QUERY = 1'b0;
  localparam logic MODE_REF   = 1'b1;

endpackage

// File: rtl/dtw_watchdog.sv
// dtw_watchdog: no-progress timer for a running DTW job.
// Ports:
//   clk, rst  - core clock, synchronous active-high reset
//   clear     - restart the count from zero (progress seen or job not running)
//   enable    - count this cycle
//   expired   - the current cycle is the TIMEOUT-th consecutive cycle
//               without progress; the owner leaves its run state on this edge
module dtw_watchdog
  import dtw_pkg::*;
#(
  parameter int TIMEOUT = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The count holds the number of finished no-progress cycles. It stops at
  // LAST because the scheduler leaves the run state on the edge where
  // expired is high.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/dtw_run_sched.sv
// dtw_run_sched: job-level sequencer for the DTW core.
// It takes one job descriptor at a time from the control master. A job is
// either a reference load or a batch of nq queries. For each job the block
// resets the core, arms it, runs it and watches for completion. It then
// reports done, or err with a reason code. All outputs are registered.
// Ports:
//   clk, rst                      - core stream clock, synchronous active-high reset
//   cmd_valid/cmd_ready           - descriptor handshake; ready only while idle
//   cmd_mode/cmd_ref_len/cmd_nq   - descriptor fields (nq unused for reference loads)
//   abort                         - abandon the job in progress
//   core_rst/core_rs/core_mode/core_ref_len - controls driven into dtw_core
//   core_busy/core_load_done      - status returned by dtw_core
//   done/err                      - one-cycle completion / failure pulses
//   err_code                      - failure reason, held until the next accepted job
//   q_done_cnt                    - queries finished in the current or last job
//   state_o                       - state encoding for the status register
module dtw_run_sched
  import dtw_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 65536,
  parameter int NQ_W       = 16,
  parameter int LEN_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_ref_len,
  input  logic [NQ_W-1:0]  cmd_nq,
  input  logic             abort,
  output logic             core_rst,
  output logic             core_rs,
  output logic             core_mode,
  output logic [LEN_W-1:0] core_ref_len,
  input  logic             core_busy,
  input  logic             core_load_done,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [NQ_W-1:0]  q_done_cnt,
  output logic [2:0]       state_o
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_t          state;
  logic [RC_W-1:0] rst_cnt;
  logic [NQ_W-1:0] nq_lat;
  logic [NQ_W-1:0] q_inc;
  logic            busy_q;
  logic            running;
  logic            busy_edge;
  logic            busy_fall;
  logic            wd_clear;
  logic            wd_expired;

  // Busy edges only count as query progress while a query batch runs. Any
  // cycle outside the run states keeps the watchdog at zero. This means
  // leaving ARM always starts the watchdog from a clean count.
  assign running   = (state == RUN_REF) || (state == RUN_Q);
  assign busy_edge = (state == RUN_Q) && (busy_q != core_busy);
  assign busy_fall = (state == RUN_Q) && busy_q && !core_busy;
  assign wd_clear  = !running || busy_edge;

  // The query count stops at all-ones instead of wrapping to zero.
  assign q_inc = (&q_done_cnt) ? q_done_cnt : q_done_cnt + NQ_W'(1);

  assign state_o = state;

  dtw_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (running),
    .expired(wd_expired)
  );

  // This is the job FSM. Each output is assigned on the edge that enters the
  // state it belongs to, so the pins show the new state's values in the same
  // cycle. Inside each active state the checks run in order: abort first,
  // then completion, then timeout. done and err default low, which makes
  // them single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      core_rst     <= 1'b1;
      core_rs      <= 1'b0;
      core_mode    <= MODE_QUERY;
      core_ref_len <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      q_done_cnt   <= '0;
      nq_lat       <= '0;
      rst_cnt      <= '0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= core_busy;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          core_rst <= 1'b0;
          core_rs  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            core_mode    <= cmd_mode;
            core_ref_len <= cmd_ref_len;
            nq_lat       <= cmd_nq;
            q_done_cnt   <= '0;
            err_code     <= ERR_NONE;
            rst_cnt      <= '0;
            cmd_ready    <= 1'b0;
            // An empty query batch finishes without touching the core.
            if ((cmd_mode == MODE_QUERY) && (cmd_nq == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RSTC;
              core_rst <= 1'b1;
            end
          end
        end

        RSTC: begin
          if (abort) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (rst_cnt == RC_LAST) begin
            state    <= ARM;
            core_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        ARM: begin
          if (abort) begin
            state    <= ERR;
            core_rst <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_ABORT;
          end else begin
            core_rs <= 1'b1;
            state   <= (core_mode == MODE_REF) ? RUN_REF : RUN_Q;
          end
        end

        RUN_REF: begin
          if (abort) begin
            state    <= ERR;
            core_rs  <= 1'b0;
            core_rst <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (core_load_done) begin
            state   <= DONE;
            core_rs <= 1'b0;
            done    <= 1'b1;
          end else if (wd_expired) begin
            state    <= ERR;
            core_rs  <= 1'b0;
            core_rst <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        RUN_Q: begin
          if (abort) begin
            state    <= ERR;
            core_rs  <= 1'b0;
            core_rst <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (busy_fall) begin
            // The falling edge that finishes the last query ends the batch
            // on this same edge.
            q_done_cnt <= q_inc;
            if (q_inc == nq_lat) begin
              state   <= DONE;
              core_rs <= 1'b0;
              done    <= 1'b1;
            end
          end else if (wd_expired) begin
            state    <= ERR;
            core_rs  <= 1'b0;
            core_rst <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        ERR: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          core_rst  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          core_rst  <= 1'b0;
          core_rs   <= 1'b0;
        end
      endcase
    end
  end

endmodule
